// File: rtl/md_scheduler_pkg.sv
// Shared op codes, FSM states and default latencies for the HI/LO multiply/divide unit.
// MD_MADD_EN enables the MADD/MSUB accumulate ops (6/7).
package md_scheduler_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

    localparam int unsigned MD_MULT_LAT = 5;
    localparam int unsigned MD_DIV_LAT  = 10;

    // Ops that occupy the unit for the multiply latency.
    function automatic logic md_is_mul(input md_op_e op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MSUB);
`endif
        return r;
    endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// Execute/decode-side handshake and HI/LO result bundle of the multiply/divide unit.
interface md_scheduler_if;
    import md_scheduler_pkg::*;

    logic        start;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_uses_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, d_uses_md,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, a, b, d_uses_md,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_scheduler_arith.sv
// md_arith: combinational product/quotient/remainder for the HI/LO unit.
// With MD_MADD_EN defined it also builds the 64-bit MADD/MSUB accumulator.
module md_arith
    import md_scheduler_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] ext_a_s, ext_b_s, prod_s, prod_u;
    logic [31:0] mag_a, mag_b, q_mag, r_mag, q_u, r_u;

    assign ext_a_s = {{32{a[31]}}, a};
    assign ext_b_s = {{32{b[31]}}, b};
    assign prod_s  = ext_a_s * ext_b_s;
    assign prod_u  = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign mag_a = a[31] ? (~a + 32'd1) : a;
    assign mag_b = b[31] ? (~b + 32'd1) : b;
    assign q_mag = (b == '0) ? '0 : mag_a / mag_b;
    assign r_mag = (b == '0) ? '0 : mag_a % mag_b;
    assign q_u   = (b == '0) ? '0 : a / b;
    assign r_u   = (b == '0) ? '0 : a % b;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (b != '0) begin
                    res_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                    res_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
                end
            end
            MD_DIVU: begin
                if (b != '0) begin
                    res_lo = q_u;
                    res_hi = r_u;
                end
            end
`ifdef MD_MADD_EN
            MD_MADD: {res_hi, res_lo} = {hi, lo} + prod_s;
            MD_MSUB: {res_hi, res_lo} = {hi, lo} - prod_s;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: multiply/divide controller owning HI/LO, modelling fixed unit latency.
// MD_MADD_EN (optional) enables MADD/MSUB; otherwise ops 6/7 are no-ops.
module md_scheduler
    import md_scheduler_pkg::*;
#(
    parameter int unsigned MULT_LAT = MD_MULT_LAT,
    parameter int unsigned DIV_LAT  = MD_DIV_LAT
) (
    input  logic           clk,
    input  logic           reset,
    md_scheduler_if.slave  md
);

    md_state_e   state;
    logic [3:0]  count;
    logic        busy_q;
    logic [31:0] hi_q, lo_q, pend_hi, pend_lo;
    logic [31:0] res_hi, res_lo;
    logic        launch;
    logic [3:0]  lat;

    md_arith u_arith (
        .op     (md.op),
        .a      (md.a),
        .b      (md.b),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        launch = 1'b0;
        lat    = 4'(MULT_LAT);
        if (md_is_mul(md.op)) begin
            launch = 1'b1;
        end else if (md.op == MD_DIV || md.op == MD_DIVU) begin
            launch = 1'b1;
            lat    = 4'(DIV_LAT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md.start) begin
                        if (launch) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            count   <= lat;
                            busy_q  <= 1'b1;
                            state   <= ST_RUN;
                        end else if (md.op == MD_MTHI) begin
                            hi_q <= md.a;
                        end else if (md.op == MD_MTLO) begin
                            lo_q <= md.a;
                        end
                    end
                end
                ST_RUN: begin
                    // A start here is ignored; stall_md keeps the pipeline from issuing one.
                    if (count == 4'd1) begin
                        hi_q   <= pend_hi;
                        lo_q   <= pend_lo;
                        busy_q <= 1'b0;
                        count  <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign md.busy     = busy_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.stall_md = md.d_uses_md & (md.start | busy_q);

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler (hand-computed HI/LO and busy lengths).
// Define MD_MADD_EN for both bench and RTL to exercise MADD/MSUB.
module tb_md_scheduler;
    import md_scheduler_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    md_scheduler_if mdif ();

    md_scheduler #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (rst_n),
        .md    (mdif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic drive_start(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdif.start = 1'b1;
        mdif.op    = op;
        mdif.a     = a;
        mdif.b     = b;
        @(posedge clk);
        #1 mdif.start = 1'b0;
    endtask

    // Counts busy negedges after the launch edge; flags any HI/LO change while busy.
    task automatic wait_idle(output int cyc, output bit changed);
        logic [31:0] h0, l0;
        h0 = mdif.hi;
        l0 = mdif.lo;
        cyc = 0;
        changed = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!mdif.busy) break;
            cyc++;
            if (mdif.hi !== h0 || mdif.lo !== l0) changed = 1'b1;
        end
    endtask

    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        bit ch;
        drive_start(op, a, b);
        wait_idle(cyc, ch);
    endtask

    task automatic test_reset();
        int cyc;
        run_op(MD_MTHI, 32'h5555_0000, 32'd0, cyc);
        run_op(MD_MTLO, 32'h0000_AAAA, 32'd0, cyc);
        @(negedge clk);
        rst_n = 1'b0;
        mdif.d_uses_md = 1'b1;
        #2;
        chk("reset_hi", mdif.hi, 32'd0);
        chk("reset_lo", mdif.lo, 32'd0);
        chk("reset_busy", 32'(mdif.busy), 32'd0);
        chk("reset_stall", 32'(mdif.stall_md), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdif.d_uses_md = 1'b0;
    endtask

    task automatic test_mult();
        int cyc, stall_cyc;
        bit changed;
        logic [31:0] h0, l0;
        @(negedge clk);
        mdif.d_uses_md = 1'b1;
        mdif.start = 1'b1;
        mdif.op    = MD_MULT;
        mdif.a     = 32'hFFFF_FFFD;
        mdif.b     = 32'd7;
        #1 chk("mult_stall_on_start", 32'(mdif.stall_md), 32'd1);
        @(posedge clk);
        #1 mdif.start = 1'b0;
        h0 = mdif.hi;
        l0 = mdif.lo;
        cyc = 0;
        stall_cyc = 0;
        changed = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mdif.stall_md) stall_cyc++;
            if (!mdif.busy) break;
            cyc++;
            if (mdif.hi !== h0 || mdif.lo !== l0) changed = 1'b1;
        end
        chk("mult_busy_cycles", 32'(cyc), 32'd5);
        chk("mult_no_stale_update", 32'(changed), 32'd0);
        chk("mult_stall_cycles", 32'(stall_cyc), 32'd5);
        chk("mult_hi", mdif.hi, 32'hFFFF_FFFF);
        chk("mult_lo", mdif.lo, 32'hFFFF_FFEB);
        chk("mult_stall_after", 32'(mdif.stall_md), 32'd0);
        mdif.d_uses_md = 1'b0;
    endtask

    task automatic test_div();
        int cyc;
        run_op(MD_DIVU, 32'd100, 32'd7, cyc);
        chk("divu_busy_cycles", 32'(cyc), 32'd10);
        chk("divu_lo", mdif.lo, 32'd14);
        chk("divu_hi", mdif.hi, 32'd2);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        chk("div_neg_lo", mdif.lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", mdif.hi, 32'hFFFF_FFFF);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        chk("div_ovf_lo", mdif.lo, 32'h8000_0000);
        chk("div_ovf_hi", mdif.hi, 32'd0);
        run_op(MD_DIV, 32'd55, 32'd0, cyc);
        chk("div0_busy_cycles", 32'(cyc), 32'd10);
        chk("div0_lo_kept", mdif.lo, 32'h8000_0000);
        chk("div0_hi_kept", mdif.hi, 32'd0);
    endtask

    task automatic test_mthi_mtlo();
        int cyc;
        run_op(MD_MTHI, 32'h0000_1234, 32'd0, cyc);
        chk("mthi_busy_cycles", 32'(cyc), 32'd0);
        chk("mthi_hi", mdif.hi, 32'h0000_1234);
        chk("mthi_lo_kept", mdif.lo, 32'h8000_0000);
        run_op(MD_MTLO, 32'hCAFE_0001, 32'd0, cyc);
        chk("mtlo_lo", mdif.lo, 32'hCAFE_0001);
    endtask

    task automatic test_start_while_busy();
        int cyc;
        drive_start(MD_MULT, 32'd6, 32'd7);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            mdif.start = (k == 1);
            mdif.op    = MD_DIVU;
            mdif.a     = 32'd9;
            mdif.b     = 32'd2;
            if (!mdif.busy) break;
            cyc++;
        end
        mdif.start = 1'b0;
        chk("busy_start_cycles", 32'(cyc), 32'd5);
        chk("busy_start_hi", mdif.hi, 32'd0);
        chk("busy_start_lo", mdif.lo, 32'd42);
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        chk("b2b_multu_hi", mdif.hi, 32'hFFFF_FFFE);
        chk("b2b_multu_lo", mdif.lo, 32'h0000_0001);
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, cyc);
        chk("b2b_divu_lo", mdif.lo, 32'h0FFF_FFFF);
        chk("b2b_divu_hi", mdif.hi, 32'h0000_000F);
    endtask

    task automatic test_reset_during_div();
        drive_start(MD_DIV, 32'd100, 32'd7);
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("abort_busy_before", 32'(mdif.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(mdif.busy), 32'd0);
        chk("abort_hi", mdif.hi, 32'd0);
        chk("abort_lo", mdif.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) @(negedge clk);
        chk("abort_discard_lo", mdif.lo, 32'd0);
        chk("abort_stays_idle", 32'(mdif.busy), 32'd0);
    endtask

`ifdef MD_MADD_EN
    task automatic test_madd();
        int cyc;
        run_op(MD_MTHI, 32'd0, 32'd0, cyc);
        run_op(MD_MTLO, 32'd1, 32'd0, cyc);
        run_op(MD_MADD, 32'd2, 32'd3, cyc);
        chk("madd_busy_cycles", 32'(cyc), 32'd5);
        chk("madd_lo", mdif.lo, 32'd7);
        chk("madd_hi", mdif.hi, 32'd0);
        run_op(MD_MSUB, 32'd2, 32'd4, cyc);
        chk("msub_lo", mdif.lo, 32'hFFFF_FFFF);
        chk("msub_hi", mdif.hi, 32'hFFFF_FFFF);
    endtask
`else
    task automatic test_madd();
        int cyc;
        run_op(MD_MTHI, 32'd0, 32'd0, cyc);
        run_op(MD_MTLO, 32'd1, 32'd0, cyc);
        run_op(MD_MADD, 32'd2, 32'd3, cyc);
        chk("madd_noop_busy", 32'(cyc), 32'd0);
        chk("madd_noop_lo", mdif.lo, 32'd1);
        run_op(MD_MSUB, 32'd2, 32'd4, cyc);
        chk("msub_noop_busy", 32'(cyc), 32'd0);
        chk("msub_noop_hi", mdif.hi, 32'd0);
    endtask
`endif

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        mdif.start = 1'b0;
        mdif.op = MD_MULT;
        mdif.a = '0;
        mdif.b = '0;
        mdif.d_uses_md = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_start_while_busy();
        test_back_to_back();
        test_madd();
        test_reset_during_div();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
